// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive FSM states and the sample voter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

endpackage

// File: rtl/rx_frame_receiver_if.sv
// Received-word handshake plus error pulses; master is the receiver, slave the consumer.
interface rx_frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 framing_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, framing_err, parity_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, framing_err, parity_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/rx_line_sync.sv
// Two-flop synchronizer for rxd plus a 3-deep tick-enabled history voted to sample_bit.
// Latency: 2 clk to rxd_sync; sample_bit reflects the last three ticks. No backpressure.
module rx_line_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic rxd,
    output logic rxd_sync,
    output logic sample_bit
);

    logic       sync1;
    logic       sync2;
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            if (sample_tick) begin
                hist <= {hist[1:0], sync2};
            end
        end
    end

    assign rxd_sync   = sync2;
    assign sample_bit = majority3(hist);

endmodule

// File: rtl/rx_frame_receiver.sv
// UART receive framer: start/data/parity/stop recovery on an oversampled tick enable.
// Word and error pulses appear 1 clk after the stop deciding tick; a held word causes overrun drops.
module rx_frame_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rxd,
    rx_frame_receiver_if.master  bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 framing_err_q;
    logic                 parity_err_q;
    logic                 overrun_err_q;
    logic                 rxd_sync;
    logic                 sample_bit;
    logic                 par_expected;

    rx_line_sync u_line_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rxd         (rxd),
        .rxd_sync    (rxd_sync),
        .sample_bit  (sample_bit)
    );

    assign par_expected = (^shreg) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RX_IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bad       <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
            if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (sample_tick) begin
                case (state)
                    RX_IDLE: begin
                        if (!rxd_sync) begin
                            state    <= RX_START;
                            tick_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            par_bad  <= 1'b0;
                            state    <= rxd_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            shreg    <= {sample_bit, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                state <= (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    RX_PARITY: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            par_bad  <= (sample_bit != par_expected);
                            state    <= RX_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            state    <= RX_IDLE;
                            // Acceptance on this same edge frees the slot, so the new word still loads.
                            if (!sample_bit) begin
                                framing_err_q <= 1'b1;
                            end else if (!rx_valid_q || bus.rx_ready) begin
                                rx_data_q    <= shreg;
                                rx_valid_q   <= 1'b1;
                                parity_err_q <= par_bad;
                            end else begin
                                overrun_err_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.framing_err = framing_err_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Directed bench for rx_frame_receiver: an 8N1 instance and an 8E1 instance share clock, tick and reset.
module tb_rx_frame_receiver;
    import uart_pkg::*;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic sample_tick = 1'b0;
    logic rxd_a       = 1'b1;
    logic rxd_p       = 1'b1;
    int   tick_period = 163;

    int checks = 0;
    int errors = 0;
    int fe_a = 0, pe_a = 0, oe_a = 0;
    int fe_p = 0, pe_p = 0, oe_p = 0;
    logic [7:0] exp_q[$];

    rx_frame_receiver_if #(.DATA_BITS(8)) bus_a ();
    rx_frame_receiver_if #(.DATA_BITS(8)) bus_p ();

    rx_frame_receiver #(.DATA_BITS(8), .PARITY(PAR_NONE), .OVERSAMPLE(16)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rxd         (rxd_a),
        .bus         (bus_a)
    );

    rx_frame_receiver #(.DATA_BITS(8), .PARITY(PAR_EVEN), .OVERSAMPLE(16)) dut_p (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rxd         (rxd_p),
        .bus         (bus_p)
    );

    always #5 clk = ~clk;

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            if (tc >= tick_period - 1) begin
                sample_tick = 1'b1;
                tc = 0;
            end else begin
                sample_tick = 1'b0;
                tc++;
            end
        end
    end

    always @(negedge clk) begin
        if (bus_a.framing_err) fe_a++;
        if (bus_a.parity_err)  pe_a++;
        if (bus_a.overrun_err) oe_a++;
        if (bus_p.framing_err) fe_p++;
        if (bus_p.parity_err)  pe_p++;
        if (bus_p.overrun_err) oe_p++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!sample_tick) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic b);
        if (sel) rxd_p = b;
        else     rxd_a = b;
    endtask

    task automatic send_bit(input bit sel, input logic b);
        set_line(sel, b);
        repeat (16) wait_tick();
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                              input logic par, input logic stop);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (with_par) send_bit(sel, par);
        send_bit(sel, stop);
        set_line(sel, 1'b1);
    endtask

    task automatic wait_valid_and_pop(input bit sel, input string tag);
        int n;
        logic v;
        logic [7:0] d;
        logic [7:0] exp;
        n = 0;
        v = sel ? bus_p.rx_valid : bus_a.rx_valid;
        while (!v && n < 200) begin
            @(negedge clk);
            n++;
            v = sel ? bus_p.rx_valid : bus_a.rx_valid;
        end
        check({tag, "_valid"}, v, 1);
        d = sel ? bus_p.rx_data : bus_a.rx_data;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_data"}, d, exp);
    endtask

    task automatic accept(input bit sel, input string tag);
        @(negedge clk);
        if (sel) bus_p.rx_ready = 1'b1;
        else     bus_a.rx_ready = 1'b1;
        @(negedge clk);
        bus_p.rx_ready = 1'b0;
        bus_a.rx_ready = 1'b0;
        #1;
        check({tag, "_cleared"}, sel ? bus_p.rx_valid : bus_a.rx_valid, 0);
    endtask

    initial begin
        int fe0, pe0, oe0;
        bus_a.rx_ready = 1'b0;
        bus_p.rx_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus_a.rx_valid, 0);
        check("rst_data", bus_a.rx_data, 0);
        check("rst_errs", {bus_a.framing_err, bus_a.parity_err, bus_a.overrun_err}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 at the real baud tick rate, held until accepted
        exp_q.push_back(8'hA5);
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        wait_valid_and_pop(0, "a5");
        repeat (400) @(negedge clk);
        check("a5_hold_valid", bus_a.rx_valid, 1);
        check("a5_hold_data", bus_a.rx_data, 8'hA5);
        accept(0, "a5");

        tick_period = 4;
        repeat (10) wait_tick();

        // Short low glitch in IDLE
        fe0 = fe_a; pe0 = pe_a; oe0 = oe_a;
        set_line(0, 1'b0);
        repeat (4) wait_tick();
        set_line(0, 1'b1);
        repeat (40) wait_tick();
        check("glitch_valid", bus_a.rx_valid, 0);
        check("glitch_errs", (fe_a - fe0) + (pe_a - pe0) + (oe_a - oe0), 0);

        // Stop bit low: framing error, no word
        fe0 = fe_a;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        repeat (20) wait_tick();
        check("frame_fe_count", fe_a - fe0, 1);
        check("frame_valid", bus_a.rx_valid, 0);

        // Even parity, wrong parity bit: delivered with parity_err
        pe0 = pe_p;
        exp_q.push_back(8'h3C);
        send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
        wait_valid_and_pop(1, "par_bad");
        check("par_bad_pe_count", pe_p - pe0, 1);
        accept(1, "par_bad");

        // Even parity, correct parity bit
        pe0 = pe_p;
        exp_q.push_back(8'h3C);
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1);
        wait_valid_and_pop(1, "par_ok");
        check("par_ok_pe_count", pe_p - pe0, 0);
        accept(1, "par_ok");

        // Back-to-back with consumer stalled: second word overruns
        oe0 = oe_a;
        exp_q.push_back(8'h11);
        send_frame(0, 8'h11, 0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1);
        repeat (4) wait_tick();
        check("ovr_oe_count", oe_a - oe0, 1);
        wait_valid_and_pop(0, "ovr");
        accept(0, "ovr");

        // Pending word, then reset in the middle of data bit 4 of the next frame
        exp_q.push_back(8'h77);
        send_frame(0, 8'h77, 0, 1'b0, 1'b1);
        wait_valid_and_pop(0, "pre_rst");
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        set_line(0, 1'b0);
        repeat (8) wait_tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus_a.rx_valid, 0);
        check("mid_rst_data", bus_a.rx_data, 0);
        check("mid_rst_errs", {bus_a.framing_err, bus_a.parity_err, bus_a.overrun_err}, 0);
        set_line(0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) wait_tick();
        fe0 = fe_a;
        exp_q.push_back(8'h5A);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        wait_valid_and_pop(0, "post_rst");
        check("post_rst_fe", fe_a - fe0, 0);
        accept(0, "post_rst");

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_receiver.md
# rx_frame_receiver

UART receive framer for the `uart_rx` path. It consumes the 16x-oversampled sample tick derived from the rx baud-rate divider and the asynchronous serial line, and recovers start/data/parity/stop framing. Each received word is delivered to the downstream consumer over a valid/ready handshake, with framing, parity and overrun error reporting. It runs entirely in the system clock domain; the sample tick is an enable, not a clock.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- OVERSAMPLE, 16, sample ticks per bit; even, ≥ 8

Ports:
- clk  input  1  system clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- sample_tick  input  1  one-clk pulse at OVERSAMPLE × baud
- rxd  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received word, LSB = first bit on the line
- rx_valid  output  1  rx_data holds an unconsumed word
- rx_ready  input  1  consumer accepts the word when high with rx_valid
- framing_err  output  1  one-clk pulse: stop bit sampled 0
- parity_err  output  1  one-clk pulse: parity mismatch
- overrun_err  output  1  one-clk pulse: word completed while rx_valid was still high

## Operation
- rxd passes through a 2-FF synchronizer, reset to 1. On each sample_tick, the synchronized bit shifts into a 3-bit history, reset to 3'b111.
- Bit value = majority of the history, evaluated on the deciding tick.
- States:
  - IDLE: on a tick with synced rxd = 0, go to START and clear tick_cnt.
  - START: on each tick, tick_cnt++. At tick_cnt = OVERSAMPLE/2−1, if synced rxd = 0 go to DATA and clear tick_cnt; otherwise it is a glitch, return to IDLE.
  - DATA: on each tick, tick_cnt++. At tick_cnt = OVERSAMPLE−1, shift in the majority bit, LSB first, and clear tick_cnt. After DATA_BITS bits, go to PARITY, or to STOP if PARITY = 0.
  - PARITY: one bit time, same deciding rule. Expected bit = XOR of data for even, its inverse for odd.
  - STOP: deciding tick as in DATA, then go to IDLE.
- On the stop deciding tick:
  - Stop bit = 1 and rx_valid low: load rx_data and set rx_valid. A parity error is still delivered, with parity_err pulsed.
  - Stop bit = 1 and rx_valid high: the new word is dropped, rx_data is unchanged, and overrun_err pulses.
  - Stop bit = 0: framing_err pulses, the word is discarded, and parity_err is suppressed.
- Handshake: rx_valid stays high and rx_data stays stable until a clk edge with rx_valid & rx_ready; rx_valid clears on that edge.
- If acceptance and a new word land on the same edge, the new word loads and rx_valid stays high. No overrun is reported.
- tick_cnt width = $clog2(OVERSAMPLE); the bit counter width = $clog2(DATA_BITS+1).

## Timing
- Reset state: state IDLE, counters 0, rx_data 0, rx_valid 0, all error pulses 0. Reset is asynchronous and may be asserted at any point, including mid-frame; the partial frame is lost.
- Synchronizer latency: 2 clk cycles.
- rx_valid and the error pulses rise 1 clk cycle after the clk edge that carries the stop-bit deciding tick.
- Return to IDLE happens at mid-stop-bit, so back-to-back frames with a single stop bit are received.
- sample_tick high on consecutive clks is legal, with each high cycle counting as one tick. No tick means no state progress.
- rx_ready is ignored while rx_valid = 0.

## Structure
- Shared package uart_pkg:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN
  - rx state enum (IDLE, START, DATA, PARITY, STOP)
- Sub-module rx_line_sync: 2-FF synchronizer plus the 3-sample majority history, clocked by clk, enabled by sample_tick, output sample_bit.
- Top module: FSM, counters, shift register, output register, and handshake logic.

## Test plan
- 8N1 0xA5 with ticks every 163 clks (25 MHz, 9600 baud ×16) and rx_ready low → rx_valid = 1, rx_data = 0xA5, held until rx_ready is pulsed, then rx_valid = 0.
- rxd low for 4 ticks in IDLE → return to IDLE, no rx_valid, no error pulses.
- 8N1 0x3C with stop bit driven 0 → framing_err pulses once, rx_valid stays 0.
- PARITY = 2, 0x3C sent with parity bit 1 → parity_err pulses and rx_data = 0x3C is valid. Same frame with parity bit 0 → no parity_err.
- Back-to-back 0x11 then 0x22 with rx_ready held low → rx_data stays 0x11 and overrun_err pulses at the second stop bit. Pulsing rx_ready then clears rx_valid.
- Assert rst_n low during data bit 4 of a frame → all outputs 0 asynchronously. After release, a following 0x5A frame is received correctly.
